mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle sequencer for the M-extension multiply/divide unit. The core dispatches an M-extension instruction (funct7 = 0000001, opcode OP) to this block with its funct3 and both operand values. The block runs a 32-iteration shift-add multiply or restoring divide, resolves the RISC-V corner cases, and returns a single 32-bit result with a one-cycle done pulse. The core holds its pipeline on `busy` and can abandon an operation with `flush` on a trap or redirect.

## Interface
- No parameters; XLEN is fixed at 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled only while `ready`=1.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  32  operand A (multiplicand / dividend).
- `rs2_val`  in  32  operand B (multiplier / divisor).
- `flush`  in  1  abort the current operation; has priority over everything except `rst`.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in RUN and DONE (the complement of `ready`).
- `done`  out  1  high for exactly one cycle, while in DONE.
- `result`  out  32  registered result; holds its value until the next completed operation.

## Operation
- State machine states are IDLE, RUN and DONE.
- On accept (IDLE with `start`=1 and `flush`=0), the block latches `funct3`, both operand magnitudes, the sign flags and `neg_res`, and clears a 5-bit iteration counter.
- Sign handling:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats A as signed and B as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
  - Signed operands are converted to magnitude (two's-complement negate if bit 31 is set).
- Divide fast paths, checked at accept; the block goes IDLE→DONE directly with these results:
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `rs1_val` unchanged.
  - DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Normal path: IDLE→RUN. Each RUN cycle performs one iteration.
- Multiply iteration:
  - 64-bit accumulator, LSB-first shift-add of |A| by the bits of |B|.
  - After iteration 32, negate the 64-bit product if the operand signs differ (signed operands only).
  - MUL selects product bits [31:0]; MULH/MULHSU/MULHU select bits [63:32].
- Divide iteration:
  - Restoring division: shift the remainder left, bring in the next dividend bit, trial-subtract |B|, set the quotient bit.
  - After iteration 32: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- Sign correction and result selection happen on the RUN→DONE edge, and `result` is written on that same edge. DONE→IDLE on the next edge.
- `start` while `ready`=0 is ignored. This includes the DONE cycle: the core must re-present the request.
- `flush`=1 in any state forces IDLE on the next edge. `done` is not asserted and `result` keeps its prior value.
- `flush`=1 together with `start`=1 in IDLE: the request is dropped and the block stays IDLE.
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, counter 0. `rst` asserted mid-operation aborts immediately, with the same effect as reset.

## Timing
- The start accept edge is edge k.
- Normal ops: RUN iterations occur on edges k+1 … k+32. DONE is entered at edge k+32, so `done`/`result` are valid in the cycle after edge k+32. `ready` returns after edge k+33. Back-to-back issue interval is 34 cycles.
- Fast-path ops: DONE is entered at edge k, so `done` is valid in the cycle after edge k. `ready` returns after edge k+1.
- Latency does not depend on operand values except for the fast paths.
- `result` is registered, with no combinational path from inputs to outputs. `ready`/`busy`/`done` decode directly from the state register.
- Operand and `funct3` inputs may change freely after the accept edge.

## Test plan
- Multiply low: MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB with `done` after edge k+32; then MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed multiply high:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0xFFFFFFFF × 1 → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Corner fast paths, each with `done` in the cycle after the accept edge:
  - DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM the same operands → 0.
- Flush and ignore:
  - Assert `flush` 10 cycles into a DIV: no `done` pulse, `ready`=1 after the next edge, `result` keeps its prior value.
  - `start` pulsed during RUN and during DONE is ignored.
  - `start` together with `flush` in IDLE leaves the block IDLE.
- Reset: assert `rst` asynchronously mid-MUL: outputs go to reset values immediately without waiting for a clock edge. After release, a new MUL 3 × 4 → 12 completes with normal latency.

Source files
------------

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - RV32 M-extension multi-cycle multiply/divide sequencer
module mdu_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1_val,
    input  logic [31:0] i_rs2_val,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;

    // Operand classification at accept time
    logic        w_is_div;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_fast_res;

    assign w_is_div   = i_funct3[2];
    // Unsigned forms are MULHU (011), DIVU (101), REMU (111); MULHSU (010) has only A signed
    assign w_a_signed = (i_funct3 != 3'b011) && (i_funct3 != 3'b101) && (i_funct3 != 3'b111);
    assign w_b_signed = w_a_signed && (i_funct3 != 3'b010);
    assign w_a_neg    = w_a_signed & i_rs1_val[31];
    assign w_b_neg    = w_b_signed & i_rs2_val[31];
    assign w_mag_a    = w_a_neg ? (~i_rs1_val + 32'd1) : i_rs1_val;
    assign w_mag_b    = w_b_neg ? (~i_rs2_val + 32'd1) : i_rs2_val;
    assign w_div_zero = w_is_div && (i_rs2_val == 32'd0);
    assign w_div_ovf  = w_is_div && !i_funct3[0] && (i_rs1_val == 32'h8000_0000)
                        && (i_rs2_val == 32'hFFFF_FFFF);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    assign w_fast_res = w_div_zero ? (i_funct3[1] ? i_rs1_val : 32'hFFFF_FFFF)
                                   : (i_funct3[1] ? 32'd0 : 32'h8000_0000);

    // Multiply step: acc = {partial_high, remaining multiplier bits}, add |A| when LSB set, shift right
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide step: acc = {remainder, dividend/quotient}, shift left and trial-subtract |B|
    logic [32:0] w_div_trial;
    logic [63:0] w_div_next;
    assign w_div_trial = r_acc[63:31] - {1'b0, r_mag_b};
    assign w_div_next  = w_div_trial[32] ? {r_acc[62:0], 1'b0}
                                         : {w_div_trial[31:0], r_acc[30:0], 1'b1};

    // Sign correction and result selection for the final iteration
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_final;
    assign w_prod = r_neg_res ? (~w_mul_next + 64'd1) : w_mul_next;
    assign w_quo  = r_neg_res ? (~w_div_next[31:0] + 32'd1) : w_div_next[31:0];
    assign w_rem  = r_neg_rem ? (~w_div_next[63:32] + 32'd1) : w_div_next[63:32];

    // Pick the architectural result for the latched funct3
    always_comb begin
        w_final = 32'd0;
        case (r_funct3)
            3'b000:                 w_final = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[63:32];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    // Sequencer FSM with registered handshake outputs and datapath state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_funct3  <= 3'd0;
            r_mag_a   <= 32'd0;
            r_mag_b   <= 32'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= 5'd0;
            r_acc     <= 64'd0;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_result  <= 32'd0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_funct3  <= i_funct3;
                        r_mag_a   <= w_mag_a;
                        r_mag_b   <= w_mag_b;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_cnt     <= 5'd0;
                        // Multiply shifts the multiplier out of the low half; divide shifts the dividend
                        r_acc     <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
                        o_ready   <= 1'b0;
                        o_busy    <= 1'b1;
                        if (w_div_zero || w_div_ovf) begin
                            o_result <= w_fast_res;
                            r_state  <= S_DONE;
                            o_done   <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            o_done  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        o_result <= w_final;
                        r_state  <= S_DONE;
                        o_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        flush = 1'b0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    mdu_sequencer dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_funct3  (funct3),
        .i_rs1_val (rs1),
        .i_rs2_val (rs2),
        .i_flush   (flush),
        .o_ready   (ready),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result)
    );

    always #5 clk = ~clk;

    // Reference result straight from RISC-V arithmetic semantics
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Model: cycles remaining until IDLE (0 = idle, 1 = done cycle)
    int          m_cnt = 0;
    logic [31:0] m_result = 32'd0;
    logic [31:0] m_pend = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            m_result <= 32'd0;
            m_pend   <= 32'd0;
        end else if (flush) begin
            m_cnt <= 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                if (ref_fast(funct3, rs1, rs2)) begin
                    m_cnt    <= 1;
                    m_result <= ref_res(funct3, rs1, rs2);
                end else begin
                    m_cnt  <= 33;
                    m_pend <= ref_res(funct3, rs1, rs2);
                end
            end
        end else begin
            if (m_cnt == 2) m_result <= m_pend;
            m_cnt <= m_cnt - 1;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        checks++;
        if (ready !== (m_cnt == 0) || busy !== (m_cnt != 0) || done !== (m_cnt == 1) || result !== m_result) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got ready=%b busy=%b done=%b result=%h want ready=%b busy=%b done=%b result=%h",
                     $time, ready, busy, done, result, (m_cnt == 0), (m_cnt != 0), (m_cnt == 1), m_result);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input bit poke_run, input bit poke_done, input string name);
        int cyc;
        cyc = 0;
        while (!ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rs1    = 32'h5A5A_1234;
        rs2    = 32'h0000_0003;
        funct3 = ~f;
        cyc = 1;
        while (!done && cyc < 100) begin
            start = poke_run && (cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_result"}, result, exp_res);
        check({name, "_model"}, m_result, exp_res);
        if (poke_done) begin
            funct3 = f;
            rs1    = a;
            rs2    = b;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({name, "_done_start_ignored"}, {31'd0, ready}, 32'd1);
            @(negedge clk);
            check({name, "_still_idle"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, 1'b0, "mul_7_m3");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, 1'b0, "mulhu_max");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 1'b0, 1'b0, "mulh_min");
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 1'b0, "mulhsu_m1");
        run_op(3'd1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33, 1'b0, 1'b0, "mulh_m1_1");
        run_op(3'd0, 32'hFFFF_FFF9,  32'hFFFF_FFFD, 32'd21,        33, 1'b0, 1'b0, "mul_m7_m3");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 1'b0, 1'b1, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 1'b0, 1'b0, "rem_m7_2");
        run_op(3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0, 1'b0, "div_7_m2");
        run_op(3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, 1'b0, 1'b0, "rem_7_m2");
        run_op(3'd5, 32'd100,        32'd7,         32'd14,        33, 1'b0, 1'b0, "divu_100_7");
        run_op(3'd7, 32'd100,        32'd7,         32'd2,         33, 1'b0, 1'b0, "remu_100_7");

        // Flush a DIV ten cycles in: no done, result keeps the REMU value
        while (!ready) @(negedge clk);
        funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {31'd0, ready}, 32'd1);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_result_kept", result, 32'd2);
        @(negedge clk);
        check("flush_no_late_done", {31'd0, done}, 32'd0);

        run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1'b0, 1'b0, "divu_by0");
        run_op(3'd6, 32'd5,          32'd0,         32'd5,         1, 1'b0, 1'b0, "rem_by0");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b0, "div_ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1'b0, 1'b1, "rem_ovf");

        // start together with flush in IDLE is dropped
        while (!ready) @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_ready", {31'd0, ready}, 32'd1);
        check("start_flush_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a MUL
        funct3 = 3'd0; rs1 = 32'h0000_1234; rs2 = 32'h0000_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", {31'd0, ready}, 32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 1'b0, 1'b0, "mul_3_4_after_rst");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
